// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary PWM pair with dead-time insertion.
//   The duty word is shadow-latched at each period boundary, so a duty input
//   that changes mid-period never produces a runt pulse. A prescaler sets the
//   PWM tick rate.
// Parameters:
//   N    - duty / period-counter width (period = 2^N-1 ticks)
//   P    - prescaler control width
//   DEAD - dead time in CLK cycles (0..15); both outputs low during it
// Ports:
//   CLK        in   system clock, rising edge
//   N_RESET    in   asynchronous active-low reset
//   DUTY       in   requested duty (N bits)
//   DIV        in   prescaler; one PWM tick every DIV+1 clocks (P bits)
//   EN         in   run enable
//   PWM_H      out  high-side drive, registered
//   PWM_L      out  low-side drive, registered
//   PERIOD_END out  one-clock pulse on the last tick of each period
//   DUTY_ACT   out  duty currently in force (shadow register)
module pwm_deadtime #(
  parameter int unsigned N    = 8,
  parameter int unsigned P    = 4,
  parameter int unsigned DEAD = 2
) (
  input  logic         CLK,
  input  logic         N_RESET,
  input  logic [N-1:0] DUTY,
  input  logic [P-1:0] DIV,
  input  logic         EN,
  output logic         PWM_H,
  output logic         PWM_L,
  output logic         PERIOD_END,
  output logic [N-1:0] DUTY_ACT
);

  localparam int unsigned  DW        = 4;
  // Last counter value of a period: 2^N-2 (all ones except the LSB).
  localparam logic [N-1:0] CNT_LAST  = {{(N-1){1'b1}}, 1'b0};
  localparam bit           DEAD_ZERO = (DEAD == 0);
  localparam logic [DW-1:0] DC_LAST  = DW'((DEAD == 0) ? 0 : DEAD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEAD_WAIT,
    HIGH_ON,
    LOW_ON
  } state_t;

  logic [P-1:0]  pre;
  logic [N-1:0]  cnt;
  state_t        state;
  logic          target;
  logic [DW-1:0] dc;

  logic tick_c;
  logic last_c;
  logic raw_c;

  // >= rather than == so a DIV decrease below the current prescale count
  // ticks immediately instead of running round the full 2^P range.
  assign tick_c = EN && (pre >= DIV);
  assign last_c = tick_c && (cnt == CNT_LAST);
  assign raw_c  = EN && (cnt < DUTY_ACT);

  // Prescaler and period counter.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      pre <= '0;
      cnt <= '0;
    end else if (!EN) begin
      pre <= '0;
      cnt <= '0;
    end else if (tick_c) begin
      pre <= '0;
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Shadow duty and period-end pulse; while disabled the shadow tracks DUTY.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      PERIOD_END <= 1'b0;
      DUTY_ACT   <= '0;
    end else begin
      PERIOD_END <= last_c;
      if (!EN || last_c) begin
        DUTY_ACT <= DUTY;
      end
    end
  end

  // Dead-time FSM; outputs are registered alongside the state.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state  <= IDLE;
      target <= 1'b0;
      dc     <= '0;
      PWM_H  <= 1'b0;
      PWM_L  <= 1'b0;
    end else if (!EN) begin
      state <= IDLE;
      dc    <= '0;
      PWM_H <= 1'b0;
      PWM_L <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state  <= DEAD_WAIT;
          target <= raw_c;
          dc     <= '0;
          PWM_H  <= 1'b0;
          PWM_L  <= 1'b0;
        end

        DEAD_WAIT: begin
          PWM_H <= 1'b0;
          PWM_L <= 1'b0;
          if (raw_c != target) begin
            // Request flipped during the gap: restart the dead time.
            target <= raw_c;
            dc     <= '0;
          end else if (DEAD_ZERO || (dc == DC_LAST)) begin
            state <= target ? HIGH_ON : LOW_ON;
            PWM_H <= target;
            PWM_L <= !target;
          end else begin
            dc <= dc + 1'b1;
          end
        end

        HIGH_ON: begin
          if (!raw_c) begin
            PWM_H  <= 1'b0;
            target <= 1'b0;
            dc     <= '0;
            if (DEAD_ZERO) begin
              state <= LOW_ON;
              PWM_L <= 1'b1;
            end else begin
              state <= DEAD_WAIT;
            end
          end
        end

        LOW_ON: begin
          if (raw_c) begin
            PWM_L  <= 1'b0;
            target <= 1'b1;
            dc     <= '0;
            if (DEAD_ZERO) begin
              state <= HIGH_ON;
              PWM_H <= 1'b1;
            end else begin
              state <= DEAD_WAIT;
            end
          end
        end

        default: begin
          state <= IDLE;
          PWM_H <= 1'b0;
          PWM_L <= 1'b0;
        end
      endcase
    end
  end

  // Shoot-through guard: the two sides must never be driven together.
  a_no_overlap: assert property (@(posedge CLK) disable iff (!N_RESET) !(PWM_H && PWM_L));

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: directed bench for pwm_deadtime.
//   Two instances share all inputs: u0 with DEAD=0 and u2 with DEAD=2.
//   Outputs are sampled 1 time unit after each rising clock edge.
module tb_pwm_deadtime;

  localparam int unsigned N = 8;
  localparam int unsigned P = 4;

  logic         CLK = 1'b0;
  logic         N_RESET;
  logic [N-1:0] DUTY;
  logic [P-1:0] DIV;
  logic         EN;

  logic         h0, l0, pe0;
  logic [N-1:0] da0;
  logic         h2, l2, pe2;
  logic [N-1:0] da2;

  int n_tests = 0;
  int n_fail  = 0;
  int ov0     = 0;
  int ov2     = 0;

  // Results of the most recent period measurement.
  int mh0, ml0, mh2, ml2, mlen;

  pwm_deadtime #(.N(N), .P(P), .DEAD(0)) u0 (
    .CLK(CLK), .N_RESET(N_RESET), .DUTY(DUTY), .DIV(DIV), .EN(EN),
    .PWM_H(h0), .PWM_L(l0), .PERIOD_END(pe0), .DUTY_ACT(da0)
  );

  pwm_deadtime #(.N(N), .P(P), .DEAD(2)) u2 (
    .CLK(CLK), .N_RESET(N_RESET), .DUTY(DUTY), .DIV(DIV), .EN(EN),
    .PWM_H(h2), .PWM_L(l2), .PERIOD_END(pe2), .DUTY_ACT(da2)
  );

  always #5 CLK = ~CLK;

  // Count any clock where both sides are driven.
  always @(negedge CLK) begin
    if (h0 && l0) ov0++;
    if (h2 && l2) ov2++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Measure one full period (PERIOD_END to PERIOD_END). If not already on a
  // PERIOD_END sample, first advance to the next one.
  task automatic measure(input bit at_pe);
    int guard;
    guard = 0;
    if (!at_pe) begin
      do begin
        step(1);
        guard++;
      end while (!pe0 && guard < 2000);
      chk("pe_wait", 32'(pe0), 1);
    end
    mh0 = 0; ml0 = 0; mh2 = 0; ml2 = 0; mlen = 0;
    do begin
      step(1);
      mlen++;
      mh0 += int'(h0);
      ml0 += int'(l0);
      mh2 += int'(h2);
      ml2 += int'(l2);
    end while (!pe0 && mlen < 2000);
  endtask

  initial begin
    int hh;
    int len;

    N_RESET = 1'b0;
    EN      = 1'b0;
    DUTY    = 8'd64;
    DIV     = 4'd0;

    // Reset state
    step(2);
    chk("rst_h0", 32'(h0), 0);
    chk("rst_l0", 32'(l0), 0);
    chk("rst_pe0", 32'(pe0), 0);
    chk("rst_da0", 32'(da0), 0);
    chk("rst_h2", 32'(h2), 0);
    chk("rst_l2", 32'(l2), 0);

    // Release with EN=0: shadow tracks DUTY, outputs stay idle.
    #2 N_RESET = 1'b1;
    step(2);
    chk("dis_da0", 32'(da0), 64);
    chk("dis_h0", 32'(h0), 0);
    chk("dis_l0", 32'(l0), 0);

    // Enable: DEAD=0 drives after 2 edges, DEAD=2 after 3 edges.
    EN = 1'b1;
    step(1);
    chk("en1_h0", 32'(h0), 0);
    chk("en1_h2", 32'(h2), 0);
    step(1);
    chk("en2_h0", 32'(h0), 1);
    chk("en2_h2", 32'(h2), 0);
    step(1);
    chk("en3_h2", 32'(h2), 1);

    // Steady state DIV=0, DUTY=64
    measure(1'b0);
    chk("d64_len", mlen, 255);
    chk("d64_h0", mh0, 64);
    chk("d64_l0", ml0, 191);
    chk("d64_h2", mh2, 62);
    chk("d64_l2", ml2, 189);

    // DUTY=0: low side constant
    DUTY = 8'd0;
    measure(1'b0);
    chk("d0_da0", 32'(da0), 0);
    chk("d0_h0", mh0, 0);
    chk("d0_l0", ml0, 255);
    chk("d0_h2", mh2, 0);
    chk("d0_l2", ml2, 255);

    // DUTY=255: high side constant after one dead time
    DUTY = 8'd255;
    measure(1'b0);
    chk("d255a_h0", mh0, 255);
    chk("d255a_l0", ml0, 0);
    chk("d255a_h2", mh2, 253);
    chk("d255a_l2", ml2, 0);
    measure(1'b1);
    chk("d255b_h2", mh2, 255);
    chk("d255b_l2", ml2, 0);

    // Shadow: duty change mid-period waits for the period end
    DUTY = 8'd64;
    measure(1'b0);
    chk("sh_pre_h0", mh0, 64);
    step(30);
    DUTY = 8'd128;
    chk("sh_mid_da0", 32'(da0), 64);
    hh  = 0;
    len = 0;
    do begin
      step(1);
      len++;
      hh += int'(h0);
    end while (!pe0 && len < 2000);
    chk("sh_rest_len", len, 225);
    chk("sh_rest_h0", hh, 34);
    chk("sh_pe_da0", 32'(da0), 128);
    chk("sh_pe_pe0", 32'(pe0), 1);
    measure(1'b1);
    chk("sh_new_h0", mh0, 128);
    chk("sh_new_l0", ml0, 127);

    // DIV=1, DUTY=64: 510-clock period
    DIV  = 4'd1;
    DUTY = 8'd64;
    measure(1'b0);
    measure(1'b1);
    chk("div1_len", mlen, 510);
    chk("div1_h0", mh0, 128);
    chk("div1_l0", ml0, 382);
    chk("div1_h2", mh2, 126);
    chk("div1_l2", ml2, 380);

    // Disable at cnt=100
    step(200);
    chk("pre_dis_l0", 32'(l0), 1);
    EN   = 1'b0;
    DUTY = 8'd200;
    step(1);
    chk("off_h0", 32'(h0), 0);
    chk("off_l0", 32'(l0), 0);
    chk("off_h2", 32'(h2), 0);
    chk("off_l2", 32'(l2), 0);
    chk("off_da0", 32'(da0), 200);
    DUTY = 8'd150;
    step(1);
    chk("off_track_da2", 32'(da2), 150);

    // Re-enable: both low for the dead time, then high side
    EN = 1'b1;
    step(1);
    chk("re1_h0", 32'(h0), 0);
    chk("re1_h2", 32'(h2), 0);
    chk("re1_l2", 32'(l2), 0);
    step(1);
    chk("re2_h0", 32'(h0), 1);
    chk("re2_h2", 32'(h2), 0);
    step(1);
    chk("re3_h2", 32'(h2), 1);
    chk("re3_l2", 32'(l2), 0);

    // Asynchronous reset between edges with PWM_H high
    #2 N_RESET = 1'b0;
    #1;
    chk("arst_h2", 32'(h2), 0);
    chk("arst_l2", 32'(l2), 0);
    chk("arst_pe2", 32'(pe2), 0);
    chk("arst_da2", 32'(da2), 0);
    chk("arst_h0", 32'(h0), 0);
    #2 N_RESET = 1'b1;
    step(1);
    chk("rel1_l2", 32'(l2), 0);
    step(1);
    chk("rel2_l2", 32'(l2), 0);
    chk("rel2_l0", 32'(l0), 1);
    step(1);
    chk("rel3_l2", 32'(l2), 1);
    chk("rel3_h2", 32'(h2), 0);

    // Never both sides driven
    chk("overlap_u0", ov0, 0);
    chk("overlap_u2", ov2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime.md
# pwm_deadtime

Downstream consumer of the up/down counter stage. Takes the counter's N-bit value as a duty setting and produces a complementary, dead-time-protected PWM pair (PWM_H / PWM_L) for a half-bridge or LED driver. Duty is shadow-latched at period boundaries, so a counter stepping mid-period never produces runt pulses. A prescaler sets the PWM tick rate.

## Interface
- N, 8: duty and period-counter width; period = 2^N−1 ticks.
- P, 4: prescaler control width.
- DEAD, 2: dead time in CLK cycles, 0..15; both outputs low during it.
- CLK  in  1  system clock, rising edge.
- N_RESET  in  1  asynchronous, active-low reset; clears all state immediately.
- DUTY  in  N  requested duty, driven from the counter's Y.
- DIV  in  P  prescaler; one PWM tick every DIV+1 clocks.
- EN  in  1  run enable.
- PWM_H  out  1  high-side drive, registered.
- PWM_L  out  1  low-side drive, registered.
- PERIOD_END  out  1  one-clock pulse on the last tick of each period.
- DUTY_ACT  out  N  duty currently in force (shadow register).

## Operation
- Reset values: PWM_H=0, PWM_L=0, PERIOD_END=0, DUTY_ACT=0, prescaler=0, period count=0, FSM=IDLE.
- Prescaler pre: tick when EN && pre>=DIV, then pre<=0; otherwise pre<=pre+1. The >= compare makes a DIV decrease take effect without a 2^P overrun.
- Period counter cnt: advances on tick over 0..2^N−2, then wraps to 0. cnt==2^N−2 on a tick is the period end.
- raw = EN && (cnt < DUTY_ACT). Compare is unsigned N-bit. DUTY=0 gives 0%; DUTY=2^N−1 gives 100%.
- Shadow load: DUTY_ACT<=DUTY on the period-end tick, with PERIOD_END=1 that same clock. While EN=0, DUTY_ACT<=DUTY every clock.
- EN=0: pre and cnt are forced to 0 and the FSM returns to IDLE on the next edge.
- FSM states: IDLE, DEAD_WAIT, HIGH_ON, LOW_ON. Registers: target (1 bit), dead counter dc.
  - IDLE: both outputs 0. When EN=1: target<=raw, dc<=0, go to DEAD_WAIT.
  - DEAD_WAIT: both outputs 0.
    - If raw!=target: target<=raw and dc<=0 (the dead time restarts).
    - Else if dc==DEAD−1 (or DEAD==0): go to HIGH_ON if target, otherwise LOW_ON.
    - Else dc<=dc+1.
  - HIGH_ON: PWM_H=1. When raw=0: go to DEAD_WAIT with target=0, or straight to LOW_ON if DEAD==0.
  - LOW_ON: PWM_L=1. Mirror of HIGH_ON.
- Invariant: PWM_H && PWM_L is never 1.

## Timing
- Outputs are registered from the FSM state.
- Counting from the clock where raw changes, the side being switched off goes low 1 clock later.
- The side being switched on goes high DEAD+1 clocks later.
- DEAD=0: swap on the same edge, 1-clock latency, no gap.
- Steady state, DIV=d, DEAD=k, duty D, 0<D<2^N−1:
  - PWM_H high (d+1)·D − k clocks per period.
  - PWM_L high (d+1)·(2^N−1−D) − k clocks per period.
  - Two gaps of k clocks each.
- Pulses shorter than DEAD clocks are swallowed; both outputs stay low.
- Period end: PERIOD_END and the DUTY_ACT update share one edge. The new duty governs cnt=0 of the next period.
- N_RESET asserted mid-period or mid-dead-time: outputs drop asynchronously. After release, operation restarts from IDLE with the dead time applied.

## Test plan
- Reset: assert N_RESET between edges with PWM_H=1 → PWM_H, PWM_L, PERIOD_END and DUTY_ACT all 0 before the next edge. Release → first drive comes after DEAD+1 clocks.
- N=8, DIV=0, DEAD=0, DUTY=64, EN=1 → PWM_H high 64 and PWM_L high 191 of every 255 clocks. PERIOD_END every 255 clocks. Never both high.
- DUTY=0 → PWM_L constant 1, PWM_H never 1. DUTY=255 → PWM_H constant 1 after the first dead time, no gaps.
- Shadow: DUTY changes 64→128 at cnt=30 → current period keeps 64. DUTY_ACT=128 on the PERIOD_END clock. Next period is 128 high.
- DEAD=2, DIV=1, DUTY=64 → PWM_H high 126 and PWM_L high 380 clocks per 510-clock period. Each transition has both low exactly 2 clocks.
- EN dropped at cnt=100 → next edge both 0, cnt=0, DUTY_ACT tracks DUTY. EN raised again → both low 2 clocks, then PWM_H high per the new duty.
